move_sequencer: RTL and testbench

// - Queues discrete motion commands (forward, pivot right/left, U-turn) and replays them one at a time on the shared stepctl pair.
// - Drives degreeL/R, motorL/R_dir, stepctl_en and driver_sel.
// - Replaces ad-hoc TURN_* states in the top FSM; the top FSM pushes commands and watches busy/seq_done.
// - Sits between the maze FSM and the two stepctl instances.

---
 rtl/move_sequencer_pkg.sv | 54 +++++
 rtl/move_sequencer_cmd_fifo.sv | 52 +++++
 rtl/move_sequencer.sv | 128 ++++++++++++
 tb/tb_move_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_sequencer_pkg.sv
// rtl/move_sequencer_pkg.sv - shared op/state codes and the move decode helper
// Contents: op_e command opcodes, state_e sequencer states, move_t wheel
// targets, CMD_W queued-command width, decode_cmd() op/degree -> move_t.
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_FWD   = 2'b00,
    OP_RIGHT = 2'b01,
    OP_LEFT  = 2'b10,
    OP_UTURN = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  // Queued command layout: {op[1:0], deg[15:0]}
  localparam int CMD_W = 18;

  typedef struct packed {
    logic        dir_l;
    logic        dir_r;
    logic [15:0] deg_l;
    logic [15:0] deg_r;
  } move_t;

  // A U-turn is a right pivot of twice the requested rotation; the doubled
  // value is formed in 17 bits so overflow clamps instead of wrapping.
  function automatic move_t decode_cmd(input logic [1:0] op, input logic [15:0] deg);
    move_t       m;
    logic [16:0] dbl;
    dbl     = {1'b0, deg} + {1'b0, deg};
    m.dir_l = 1'b0;
    m.dir_r = 1'b0;
    m.deg_l = deg;
    m.deg_r = deg;
    case (op_e'(op))
      OP_RIGHT: m.dir_r = 1'b1;
      OP_LEFT:  m.dir_l = 1'b1;
      OP_UTURN: begin
        m.dir_r = 1'b1;
        m.deg_l = dbl[16] ? 16'hFFFF : dbl[15:0];
        m.deg_r = m.deg_l;
      end
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/move_sequencer_cmd_fifo.sv
// rtl/move_sequencer_cmd_fifo.sv - synchronous command FIFO with flush
// Ports: WF_CLK clock; rst_n sync active-low reset; push/pop requests
// (ignored when full/empty); flush empties the queue; wdata in, rdata = head;
// full/empty status.
module move_sequencer_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             WF_CLK,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge WF_CLK) begin
    if (!rst_n || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (do_push && rst_n && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - queues motion commands and replays them on the stepctl pair
// Ports: WF_CLK, rst_n (sync active-low); cmd_valid/cmd_ready/cmd_op/cmd_deg
// command push; abort level flush+stop; step_done from stepctl pair;
// stepctl_en start pulse; degreeL/R, motorL/R_dir held targets; driver_sel
// stepctl owns motors; busy; seq_done pulse when the queue drains; fault
// sticky timeout.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int          DEPTH       = 4,
  parameter logic [15:0] SETTLE_CYC  = 16'd1600,
  parameter logic [31:0] TIMEOUT_CYC = 32'd48000000,
  parameter int          START_IGN   = 2
) (
  input  logic        WF_CLK,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_deg,
  input  logic        abort,
  input  logic        step_done,
  output logic        stepctl_en,
  output logic [15:0] degreeL,
  output logic [15:0] degreeR,
  output logic        motorL_dir,
  output logic        motorR_dir,
  output logic        driver_sel,
  output logic        busy,
  output logic        seq_done,
  output logic        fault
);

  localparam logic [31:0] SETTLE_LAST  = {16'd0, SETTLE_CYC} - 32'd1;
  localparam logic [31:0] TIMEOUT_LAST = TIMEOUT_CYC - 32'd1;
  localparam logic [31:0] IGN_CYC      = 32'(START_IGN);

  state_e           state;
  state_e           next_state;
  logic [31:0]      cnt;
  logic             ready_en;
  logic             seq_done_q;
  move_t            mv;
  logic             drive;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CMD_W-1:0] fifo_rdata;

  // ready_en keeps cmd_ready low while rst_n is held and for the reset edge.
  assign cmd_ready = ready_en & ~fifo_full & ~fault & ~abort;
  assign fifo_push = cmd_valid & cmd_ready;

  move_sequencer_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .WF_CLK (WF_CLK),
    .rst_n  (rst_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .flush  (fifo_flush),
    .wdata  ({cmd_op, cmd_deg}),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge WF_CLK) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (!fifo_empty) next_state = S_ARM;
      S_ARM:    next_state = S_RUN;
      S_RUN: begin
        // step_done is stale for the first START_IGN cycles while stepctl
        // picks up the start pulse; a finished move wins over a timeout.
        if (step_done && (cnt >= IGN_CYC)) next_state = S_SETTLE;
        else if (cnt == TIMEOUT_LAST)      next_state = S_FAULT;
      end
      S_SETTLE: if (cnt == SETTLE_LAST) next_state = fifo_empty ? S_IDLE : S_ARM;
      S_FAULT:  next_state = S_FAULT;
      default:  next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // The head is popped on the same edge that enters ARM.
  assign fifo_pop   = (next_state == S_ARM);
  assign fifo_flush = abort | (next_state == S_FAULT);

  always_ff @(posedge WF_CLK) begin
    if (!rst_n) begin
      cnt        <= '0;
      ready_en   <= 1'b0;
      seq_done_q <= 1'b0;
      mv         <= '0;
    end else begin
      ready_en   <= 1'b1;
      seq_done_q <= (state == S_SETTLE) && (next_state == S_IDLE) && !abort;
      if (((state == S_RUN) || (state == S_SETTLE)) && (next_state == state))
        cnt <= cnt + 32'd1;
      else
        cnt <= '0;
      if (abort)         mv <= '0;
      else if (fifo_pop) mv <= decode_cmd(fifo_rdata[17:16], fifo_rdata[15:0]);
    end
  end

  assign drive      = (state == S_ARM) || (state == S_RUN) || (state == S_SETTLE);
  // abort gates the motor handoff combinationally, ahead of the state change.
  assign stepctl_en = (state == S_ARM) & ~abort;
  assign driver_sel = drive & ~abort;
  assign degreeL    = drive ? mv.deg_l : 16'd0;
  assign degreeR    = drive ? mv.deg_r : 16'd0;
  assign motorL_dir = drive & mv.dir_l;
  assign motorR_dir = drive & mv.dir_r;
  assign busy       = (state != S_IDLE) | ~fifo_empty;
  assign seq_done   = seq_done_q;
  assign fault      = (state == S_FAULT);

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - scoreboard bench for move_sequencer
module tb_move_sequencer;

  localparam int SETTLE = 1600;
  localparam int IGN    = 2;
  localparam int TMO    = 1000;

  logic        WF_CLK;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_deg;
  logic        abort;
  logic        step_done;
  logic        stepctl_en;
  logic [15:0] degreeL;
  logic [15:0] degreeR;
  logic        motorL_dir;
  logic        motorR_dir;
  logic        driver_sel;
  logic        busy;
  logic        seq_done;
  logic        fault;

  move_sequencer #(
    .DEPTH       (4),
    .SETTLE_CYC  (16'd1600),
    .TIMEOUT_CYC (32'd1000),
    .START_IGN   (2)
  ) dut (
    .WF_CLK     (WF_CLK),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_deg    (cmd_deg),
    .abort      (abort),
    .step_done  (step_done),
    .stepctl_en (stepctl_en),
    .degreeL    (degreeL),
    .degreeR    (degreeR),
    .motorL_dir (motorL_dir),
    .motorR_dir (motorR_dir),
    .driver_sel (driver_sel),
    .busy       (busy),
    .seq_done   (seq_done),
    .fault      (fault)
  );

  typedef struct packed {
    logic        dl;
    logic        dr;
    logic [15:0] gl;
    logic [15:0] gr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   seq_cnt  = 0;
  int   sd_delay = 50;
  bit   sd_stuck0 = 0;
  bit   sd_stuck1 = 0;

  initial WF_CLK = 1'b0;
  always #5 WF_CLK = ~WF_CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input int deg);
    exp_t e;
    int   d;
    d    = deg;
    e.dl = (op == 2);
    e.dr = (op == 1) || (op == 3);
    if (op == 3) d = (2 * deg > 65535) ? 65535 : 2 * deg;
    e.gl = d[15:0];
    e.gr = d[15:0];
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge WF_CLK);
      #1;
    end
  endtask

  task automatic push_cmd(input int op, input int deg);
    bit ok;
    ok        = 0;
    cmd_op    = op[1:0];
    cmd_deg   = deg[15:0];
    cmd_valid = 1'b1;
    for (int n = 0; n < 20000 && !ok; n++) begin
      @(negedge WF_CLK);
      if (cmd_ready) begin
        ok = 1;
        exp_q.push_back(model(op, deg));
      end
      @(posedge WF_CLK);
      #1;
    end
    cmd_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'(1));
  endtask

  task automatic wait_arm();
    bit seen;
    seen = 0;
    for (int n = 0; n < 5000 && !seen; n++) begin
      @(negedge WF_CLK);
      if (stepctl_en) seen = 1;
    end
    check("arm_seen", 64'(seen), 64'(1));
  endtask

  // Counts rising edges from the current negedge until seq_done (which=0)
  // or fault (which=1) is observed; -1 if the budget runs out.
  task automatic cycles_until(input int which, output int n);
    bit seen;
    seen = 0;
    n    = 0;
    while (!seen && n < 5000) begin
      @(posedge WF_CLK);
      n++;
      @(negedge WF_CLK);
      if ((which == 0) ? seq_done : fault) seen = 1;
    end
    if (!seen) n = -1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int n = 0; n < 40000 && !done; n++) begin
      @(negedge WF_CLK);
      if (!busy && exp_q.size() == 0) done = 1;
    end
    check("drain_idle", 64'(done), 64'(1));
    tick(3);
  endtask

  // stepctl stand-in: step_done drops on the start pulse and rises again
  // sd_delay cycles later, unless forced stuck high or low.
  initial begin
    int run_left;
    run_left  = 0;
    step_done = 1'b0;
    forever begin
      @(posedge WF_CLK);
      #1;
      if (sd_stuck1) step_done = 1'b1;
      else if (stepctl_en) begin
        step_done = 1'b0;
        run_left  = sd_delay;
      end else if (run_left > 0) run_left--;
      else if (!sd_stuck0) step_done = 1'b1;
    end
  end

  // Monitor: every start pulse must carry the next queued move, and the
  // targets must stay put while stepctl owns the motors.
  initial begin
    exp_t e;
    exp_t held;
    bit   held_v;
    held_v = 0;
    held   = '0;
    forever begin
      @(negedge WF_CLK);
      if (seq_done) seq_cnt++;
      if (stepctl_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL arm_unexpected: got a start pulse with no move queued in the model");
        end else begin
          e = exp_q.pop_front();
          check("arm_move", 64'({driver_sel, motorL_dir, motorR_dir, degreeL, degreeR}),
                64'({1'b1, e.dl, e.dr, e.gl, e.gr}));
          held   = e;
          held_v = 1;
        end
      end else if (driver_sel && held_v) begin
        check("hold_move", 64'({motorL_dir, motorR_dir, degreeL, degreeR}),
              64'({held.dl, held.dr, held.gl, held.gr}));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    int  s0;
    int  op;
    int  deg;
    bit  bad;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_deg   = 16'd0;
    abort     = 1'b0;

    // reset
    tick(5);
    @(negedge WF_CLK);
    check("reset_outputs", 64'({cmd_ready, stepctl_en, degreeL, degreeR, motorL_dir, motorR_dir,
                                driver_sel, busy, seq_done, fault}), 64'(0));
    @(posedge WF_CLK);
    #1 rst_n = 1'b1;
    @(posedge WF_CLK);
    #1;
    @(negedge WF_CLK);
    check("ready_after_reset", 64'({cmd_ready, busy}), 64'(2'b10));
    tick(1);

    // single FWD 360
    s0       = seq_cnt;
    sd_delay = 50;
    push_cmd(0, 360);
    @(negedge WF_CLK);
    check("arm_not_early", 64'(stepctl_en), 64'(0));
    @(negedge WF_CLK);
    check("arm_latency", 64'(stepctl_en), 64'(1));
    bad = 1;
    for (int k = 0; k < 2000 && bad; k++) begin
      if (step_done) bad = 0;
      else @(negedge WF_CLK);
    end
    check("step_done_rose", 64'(bad), 64'(0));
    cycles_until(0, n);
    check("settle_length", 64'(n), 64'(1 + SETTLE));
    check("idle_at_seq_done", 64'(busy), 64'(0));
    @(negedge WF_CLK);
    check("seq_done_one_cycle", 64'(seq_done), 64'(0));
    tick(2);
    check("fwd_seq_count", 64'(seq_cnt - s0), 64'(1));

    // fill the queue behind a long move
    s0       = seq_cnt;
    sd_delay = 300;
    push_cmd(0, 5);
    push_cmd(1, 90);
    push_cmd(2, 90);
    push_cmd(3, 40000);
    push_cmd(0, 10);
    @(negedge WF_CLK);
    check("ready_low_when_full", 64'(cmd_ready), 64'(0));
    bad = 0;
    n   = 0;
    while (!stepctl_en && n < 5000) begin
      if (cmd_ready) bad = 1;
      @(negedge WF_CLK);
      n++;
    end
    check("ready_held_low_until_pop", 64'(bad), 64'(0));
    check("ready_after_pop", 64'(cmd_ready), 64'(1));
    @(posedge WF_CLK);
    #1 sd_delay = 20;
    wait_idle();
    check("queue_seq_count", 64'(seq_cnt - s0), 64'(1));

    // step_done stuck high still gets START_IGN run cycles
    sd_stuck1 = 1;
    push_cmd(1, 45);
    wait_arm();
    cycles_until(0, n);
    check("stuck_high_run_length", 64'(n), 64'(IGN + 2 + SETTLE));
    @(posedge WF_CLK);
    #1 sd_stuck1 = 0;
    tick(2);

    // timeout with step_done stuck low
    sd_stuck0 = 1;
    push_cmd(0, 100);
    push_cmd(2, 50);
    wait_arm();
    cycles_until(1, n);
    check("timeout_cycle", 64'(n), 64'(TMO + 1));
    check("fault_outputs", 64'({fault, driver_sel, cmd_ready, degreeL}), 64'({1'b1, 1'b0, 1'b0, 16'h0}));
    exp_q.delete();
    @(posedge WF_CLK);
    #1 abort = 1'b1;
    @(posedge WF_CLK);
    #1 abort = 1'b0;
    sd_stuck0 = 0;
    @(negedge WF_CLK);
    check("abort_clears_fault", 64'({fault, busy, cmd_ready}), 64'(3'b001));
    tick(2);

    // abort mid-run with two moves queued
    s0       = seq_cnt;
    sd_delay = 400;
    push_cmd(0, 1000);
    push_cmd(2, 77);
    push_cmd(1, 88);
    tick(50);
    abort = 1'b1;
    @(negedge WF_CLK);
    check("abort_gate", 64'({stepctl_en, driver_sel, cmd_ready}), 64'(0));
    exp_q.delete();
    @(posedge WF_CLK);
    #1 abort = 1'b0;
    @(negedge WF_CLK);
    check("abort_idle", 64'({busy, seq_done}), 64'(0));
    tick(1700);
    check("no_seq_done_after_abort", 64'(seq_cnt - s0), 64'(0));
    s0       = seq_cnt;
    sd_delay = 30;
    push_cmd(3, 100);
    wait_idle();
    check("post_abort_seq_count", 64'(seq_cnt - s0), 64'(1));

    // randomized stream, with the U-turn clamp boundary first
    s0 = seq_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        op  = 3;
        deg = 32767;
      end else if (i == 1) begin
        op  = 3;
        deg = 32768;
      end else begin
        op  = int'($urandom_range(0, 3));
        deg = int'($urandom_range(0, 65535));
      end
      sd_delay = int'($urandom_range(0, 40));
      push_cmd(op, deg);
      tick(int'($urandom_range(0, 3)));
    end
    wait_idle();
    check("random_seq_count", 64'(seq_cnt - s0), 64'(1));
    check("random_no_fault", 64'(fault), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
